// File: rtl/morra_cinese.sv
// Rock-paper-scissors match referee: judges one round per cycle, keeps score and
// declares the match result once a player leads by two or the programmed length runs out.
module morra_cinese (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] g1,
  input  logic [1:0] g2,
  output logic [1:0] manche,
  output logic [1:0] partita
);

  typedef enum logic [1:0] {StIdle, StPlay, StOver} state_e;

  localparam logic [1:0] MoveNone     = 2'b00;
  localparam logic [1:0] MoveRock     = 2'b01;
  localparam logic [1:0] MovePaper    = 2'b10;
  localparam logic [1:0] MoveScissors = 2'b11;

  localparam logic [1:0] ResNone = 2'b00;
  localparam logic [1:0] ResP1   = 2'b01;
  localparam logic [1:0] ResP2   = 2'b10;
  localparam logic [1:0] ResTie  = 2'b11;

  state_e     state_q, state_d;
  logic [4:0] max_q, max_d;
  logic [4:0] played_q, played_d;
  logic [4:0] w1_q, w1_d;
  logic [4:0] w2_q, w2_d;
  // {winner, winning move} of the last decisive round; all zero means no restriction
  logic [3:0] last_q, last_d;
  logic [1:0] manche_q, manche_d;
  logic [1:0] partita_q, partita_d;

  logic       p1_beats_p2;
  logic       repeat_move;
  logic       round_valid;
  logic [4:0] diff;

  assign p1_beats_p2 = (g1 == MoveRock     && g2 == MoveScissors) ||
                       (g1 == MoveScissors && g2 == MovePaper)    ||
                       (g1 == MovePaper    && g2 == MoveRock);

  assign repeat_move = (last_q[3:2] == ResP1 && g1 == last_q[1:0]) ||
                       (last_q[3:2] == ResP2 && g2 == last_q[1:0]);

  assign round_valid = (g1 != MoveNone) && (g2 != MoveNone) && !repeat_move;

  assign diff = (w1_d > w2_d) ? (w1_d - w2_d) : (w2_d - w1_d);

  always_comb begin
    state_d   = state_q;
    max_d     = max_q;
    played_d  = played_q;
    w1_d      = w1_q;
    w2_d      = w2_q;
    last_d    = last_q;
    manche_d  = ResNone;
    partita_d = partita_q;

    if (start) begin
      max_d     = {1'b0, g1, g2} + 5'd4;
      played_d  = '0;
      w1_d      = '0;
      w2_d      = '0;
      last_d    = '0;
      partita_d = ResNone;
      state_d   = StPlay;
    end else if (state_q == StPlay && round_valid) begin
      played_d = played_q + 5'd1;
      if (g1 == g2) begin
        manche_d = ResTie;
        last_d   = '0;
      end else if (p1_beats_p2) begin
        manche_d = ResP1;
        w1_d     = w1_q + 5'd1;
        last_d   = {ResP1, g1};
      end else begin
        manche_d = ResP2;
        w2_d     = w2_q + 5'd1;
        last_d   = {ResP2, g2};
      end

      // End conditions use the counts including this round
      if (played_d >= 5'd4 && diff >= 5'd2) begin
        partita_d = (w1_d > w2_d) ? ResP1 : ResP2;
        state_d   = StOver;
      end else if (played_d == max_q) begin
        if (w1_d > w2_d)      partita_d = ResP1;
        else if (w2_d > w1_d) partita_d = ResP2;
        else                  partita_d = ResTie;
        state_d = StOver;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      max_q     <= '0;
      played_q  <= '0;
      w1_q      <= '0;
      w2_q      <= '0;
      last_q    <= '0;
      manche_q  <= ResNone;
      partita_q <= ResNone;
    end else begin
      state_q   <= state_d;
      max_q     <= max_d;
      played_q  <= played_d;
      w1_q      <= w1_d;
      w2_q      <= w2_d;
      last_q    <= last_d;
      manche_q  <= manche_d;
      partita_q <= partita_d;
    end
  end

  assign manche  = manche_q;
  assign partita = partita_q;

endmodule

// File: tb/tb_morra_cinese.sv
// Scoreboard bench for morra_cinese: expected {manche, partita} is queued as each
// cycle is driven and compared one cycle later.
module tb_morra_cinese;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] g1;
  logic [1:0] g2;
  logic [1:0] manche;
  logic [1:0] partita;

  logic [3:0] exp_q [$];
  int         checks;
  int         errors;

  morra_cinese dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .g1     (g1),
    .g2     (g2),
    .manche (manche),
    .partita(partita)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle and queue its expected {manche, partita}
  task automatic drive(input logic st, input logic [1:0] a, input logic [1:0] b,
                       input logic [3:0] exp_v);
    start = st;
    g1    = a;
    g2    = b;
    exp_q.push_back(exp_v);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Table entries: {start, g1, g2, manche, partita}
  task automatic test_reset();
    logic [3:0] got, e;
    checks++;
    if ({manche, partita} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: got %b expected 0000", {manche, partita});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    drive(1'b1, 2'b00, 2'b00, 4'b0000);
    got = {manche, partita}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset_start: got %b expected %b", got, e); end
    drive(1'b0, 2'b01, 2'b10, 4'b1000);
    got = {manche, partita}; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset_round: got %b expected %b", got, e); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({manche, partita} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async: got %b expected 0000", {manche, partita});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 2'b01, 2'b10, 4'b0000);
      got = {manche, partita}; e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_invalid();
    logic [8:0] tbl [6];
    logic [3:0] got, e;
    tbl = '{9'b1_00_00_0000, 9'b0_01_10_1000, 9'b0_11_10_0000,
            9'b0_00_01_0000, 9'b0_11_11_1100, 9'b0_01_01_1100};
    foreach (tbl[i]) begin
      drive(tbl[i][8], tbl[i][7:6], tbl[i][5:4], tbl[i][3:0]);
      got = {manche, partita}; e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL invalid[%0d]: got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_early_win();
    logic [8:0] tbl [7];
    logic [3:0] got, e;
    tbl = '{9'b1_11_11_0000, 9'b0_01_10_1000, 9'b0_10_11_1000, 9'b0_11_01_1000,
            9'b0_01_10_1010, 9'b0_10_01_0010, 9'b0_01_11_0010};
    foreach (tbl[i]) begin
      drive(tbl[i][8], tbl[i][7:6], tbl[i][5:4], tbl[i][3:0]);
      got = {manche, partita}; e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL early_win[%0d]: got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_max_draw();
    logic [8:0] tbl [6];
    logic [3:0] got, e;
    tbl = '{9'b1_00_00_0000, 9'b0_01_10_1000, 9'b0_10_01_0100, 9'b0_01_10_1000,
            9'b0_10_01_0111, 9'b0_01_10_0011};
    foreach (tbl[i]) begin
      drive(tbl[i][8], tbl[i][7:6], tbl[i][5:4], tbl[i][3:0]);
      got = {manche, partita}; e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL max_draw[%0d]: got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_max_winner();
    logic [8:0] tbl [6];
    logic [3:0] got, e;
    tbl = '{9'b1_00_01_0000, 9'b0_01_10_1000, 9'b0_10_01_0100, 9'b0_11_10_0100,
            9'b0_10_01_0101, 9'b0_11_10_0001};
    foreach (tbl[i]) begin
      drive(tbl[i][8], tbl[i][7:6], tbl[i][5:4], tbl[i][3:0]);
      got = {manche, partita}; e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL max_winner[%0d]: got %b expected %b", i, got, e);
      end
    end
  endtask

  // P1 leads 2-0 before the restart; a carried score would end the match early,
  // and a kept repeat restriction would void P1's scissors.
  task automatic test_back_to_back();
    logic [8:0] tbl [8];
    logic [3:0] got, e;
    tbl = '{9'b1_01_10_0000, 9'b0_01_11_0100, 9'b0_11_10_0100, 9'b1_01_10_0000,
            9'b0_11_10_0100, 9'b0_01_11_0100, 9'b0_10_01_0100, 9'b0_11_10_0101};
    foreach (tbl[i]) begin
      drive(tbl[i][8], tbl[i][7:6], tbl[i][5:4], tbl[i][3:0]);
      got = {manche, partita}; e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %b expected %b", i, got, e);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    g1     = 2'b00;
    g2     = 2'b00;
    #12;
    test_reset();
    test_invalid();
    test_early_win();
    test_max_draw();
    test_max_winner();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
